// File: rtl/mmcm_rcfg_seq.sv
// Sequencer that sits in front of the MMCM DRP engine.
// On a request, it reads NWORDS 48-bit DRP words for the selected profile
// from a synchronous ROM and packs them into RCREG. It then runs the
// RCEN/RCRDY handshake with the engine and reports the outcome.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   REQ, PROF_SEL   request strobe and profile index (accepted only in IDLE)
//   BUSY, DONE, ERR status: in progress, success pulse, sticky timeout
//   ROM_ADDR/EN     ROM read port, address = {profile, word index}
//   ROM_DATA        ROM read data, valid one cycle after ROM_EN
//   RCREG           packed DRP words, word w at [w*48 +: 48]
//   RCEN, RCRDY     reconfiguration enable / engine ready
module mmcm_rcfg_seq #(
    parameter int unsigned PROF_W = 3,
    parameter int unsigned NWORDS = 12,
    parameter int unsigned TO_W   = 20
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ,
    input  logic [PROF_W-1:0]   PROF_SEL,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [PROF_W+3:0]   ROM_ADDR,
    output logic                ROM_EN,
    input  logic [47:0]         ROM_DATA,
    output logic [575:0]        RCREG,
    output logic                RCEN,
    input  logic                RCRDY
);

    localparam int unsigned WORD_W = 48;
    localparam int unsigned SLOTS  = 12;
    localparam int unsigned RC_W   = SLOTS * WORD_W;
    localparam int unsigned ADDR_W = PROF_W + 4;
    localparam logic [3:0]      LAST_IDX = 4'(NWORDS - 1);
    // Exiting when the count is one short of all-ones yields 2**TO_W-1 wait cycles.
    localparam logic [TO_W-1:0] TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ARM,
        S_KICK,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FIN
    } state_t;

    state_t              state_q, state_nxt;
    logic [PROF_W-1:0]   prof_q, prof_nxt;
    logic [3:0]          widx_q, widx_nxt;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_nxt;
    logic                err_q, err_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                rcen_q, rcen_nxt;
    logic                rom_en_q, rom_en_nxt;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_nxt;
    logic                cap_vld_q;
    logic [3:0]          cap_idx_q;
    logic [RC_W-1:0]     rcreg_q;
    logic                to_hit;
    logic                waiting;

    // Next-state and registered-output decode
    always_comb begin
        state_nxt    = state_q;
        prof_nxt     = prof_q;
        widx_nxt     = widx_q;
        err_nxt      = err_q;
        to_hit       = (to_cnt_q == TO_LAST);
        waiting      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    prof_nxt  = PROF_SEL;
                    err_nxt   = 1'b0;
                    widx_nxt  = 4'd0;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (widx_q == LAST_IDX) begin
                    state_nxt = S_ARM;
                end else begin
                    widx_nxt = widx_q + 4'd1;
                end
            end
            S_ARM: begin
                waiting = 1'b1;
                if (RCRDY) begin
                    state_nxt = S_KICK;
                end else if (to_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_KICK: begin
                state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                waiting = 1'b1;
                if (!RCRDY) begin
                    state_nxt = S_WAIT_DONE;
                end else if (to_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                waiting = 1'b1;
                if (RCRDY) begin
                    state_nxt = S_FIN;
                end else if (to_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Counter restarts on every state change and only runs while waiting
        if (state_nxt != state_q || !waiting) begin
            to_cnt_nxt = '0;
        end else begin
            to_cnt_nxt = to_cnt_q + TO_W'(1);
        end

        busy_nxt     = state_nxt inside {S_FETCH, S_ARM, S_KICK, S_WAIT_ACK, S_WAIT_DONE};
        done_nxt     = (state_nxt == S_FIN);
        rcen_nxt     = (state_nxt == S_KICK);
        rom_en_nxt   = (state_nxt == S_FETCH);
        rom_addr_nxt = rom_en_nxt ? {prof_nxt, widx_nxt} : rom_addr_q;
    end

    // State, status and ROM capture registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            prof_q     <= '0;
            widx_q     <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rcen_q     <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= '0;
            rcreg_q    <= '0;
        end else begin
            state_q    <= state_nxt;
            prof_q     <= prof_nxt;
            widx_q     <= widx_nxt;
            to_cnt_q   <= to_cnt_nxt;
            err_q      <= err_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            rcen_q     <= rcen_nxt;
            rom_en_q   <= rom_en_nxt;
            rom_addr_q <= rom_addr_nxt;
            // ROM data lands one cycle after the read, so track which slot it belongs to
            cap_vld_q  <= rom_en_q;
            cap_idx_q  <= rom_addr_q[3:0];
            for (int unsigned w = 0; w < SLOTS; w++) begin
                if (w < NWORDS && cap_vld_q && cap_idx_q == 4'(w)) begin
                    rcreg_q[w*WORD_W +: WORD_W] <= ROM_DATA;
                end
            end
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ROM_EN   = rom_en_q;
    assign ROM_ADDR = rom_addr_q;
    assign RCREG    = rcreg_q;
    // Masked by RST so the engine never sees an enable during a reset cycle
    assign RCEN     = rcen_q & ~RST;

endmodule
